// File: rtl/timer_cmp_multi.sv
// timer_cmp_multi: NUM_CH compare channels against an external counter, register-mapped.
// Define TIMER_CMP_MISSED_EN to build the per-channel missed (overrun) flags.
module timer_cmp_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [11:0]       tim_paddr,
    input  logic [31:0]       tim_pwdata,
    input  logic [3:0]        tim_pstrb,
    output logic [31:0]       tim_prdata,
    input  logic [CNT_W-1:0]  cnt_val,
    output logic [NUM_CH-1:0] tim_int,
    output logic              tim_int_any,
    output logic              reg_error_flag
);

    localparam bit NARROW = (CNT_W == 32);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    logic [CNT_W-1:0]  cmp     [NUM_CH];
    logic [CNT_W-1:0]  prd     [NUM_CH];
    logic [CNT_W-1:0]  cmp_nxt [NUM_CH];
    logic [CNT_W-1:0]  prd_nxt [NUM_CH];
    logic [63:0]       cmp_x   [NUM_CH];
    logic [63:0]       prd_x   [NUM_CH];
    logic [NUM_CH-1:0] int_en, mode, ch_en, status;
    logic [NUM_CH-1:0] int_en_nxt, mode_nxt, ch_en_nxt, status_nxt;
    logic [NUM_CH-1:0] match, ch_sel, wr_sel, clr_status, missed_rd;

    logic [2:0] ch_idx;
    logic [4:0] reg_off;
    logic       in_ch_space, is_summary, ch_valid;
    logic       off_cmp_lo, off_cmp_hi, off_prd_lo, off_prd_hi, off_ctrl, off_sts;
    logic       off_known, mapped, err_ro, err_hi, err_prd, wr_ok;

    // Channel window is 0x100..0x1FF, 0x20 bytes per channel
    assign in_ch_space = (tim_paddr[11:8] == 4'h1);
    assign is_summary  = (tim_paddr == 12'h0F0);
    assign ch_idx      = tim_paddr[7:5];
    assign reg_off     = tim_paddr[4:0];

    assign off_cmp_lo = (reg_off == 5'h00);
    assign off_cmp_hi = (reg_off == 5'h04);
    assign off_prd_lo = (reg_off == 5'h08);
    assign off_prd_hi = (reg_off == 5'h0C);
    assign off_ctrl   = (reg_off == 5'h10);
    assign off_sts    = (reg_off == 5'h14);
    assign off_known  = off_cmp_lo | off_cmp_hi | off_prd_lo | off_prd_hi | off_ctrl | off_sts;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_sel[c] = in_ch_space && (ch_idx == 3'(c));
        assign match[c]  = ch_en[c] && (cnt_val == cmp[c]);
        assign cmp_x[c]  = 64'(cmp[c]);
        assign prd_x[c]  = 64'(prd[c]);
    end

    assign ch_valid = |ch_sel;
    assign mapped   = is_summary || (ch_valid && off_known);
    assign err_ro   = wr_en && is_summary;
    assign err_hi   = wr_en && ch_valid && (off_cmp_hi || off_prd_hi) && NARROW;
    assign err_prd  = wr_en && (off_prd_lo || off_prd_hi) && (|(ch_sel & ch_en));

    assign reg_error_flag = ((wr_en || rd_en) && !mapped) || err_ro || err_hi || err_prd;

    assign wr_ok      = wr_en && !reg_error_flag;
    assign wr_sel     = ch_sel & {NUM_CH{wr_ok}};
    assign clr_status = wr_sel & {NUM_CH{off_sts && tim_pstrb[0] && tim_pwdata[0]}};

    assign tim_int     = status & int_en;
    assign tim_int_any = |tim_int;

`ifdef TIMER_CMP_MISSED_EN
    logic [NUM_CH-1:0] missed, missed_nxt, clr_missed;

    assign clr_missed = wr_sel & {NUM_CH{off_sts && tim_pstrb[0] && tim_pwdata[1]}};
    assign missed_rd  = missed;

    // A coinciding status clear absorbs the new match, so no overrun is recorded
    always_comb begin
        missed_nxt = missed & ~clr_missed;
        missed_nxt = missed_nxt | (match & status & ~clr_status);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) missed <= '0;
        else         missed <= missed_nxt;
    end
`else
    assign missed_rd = '0;
`endif

    always_comb begin
        tim_prdata = '0;
        if (is_summary) tim_prdata = 32'(tim_int);
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) begin
                if (off_cmp_lo) tim_prdata = cmp_x[c][31:0];
                if (off_cmp_hi) tim_prdata = cmp_x[c][63:32];
                if (off_prd_lo) tim_prdata = prd_x[c][31:0];
                if (off_prd_hi) tim_prdata = prd_x[c][63:32];
                if (off_ctrl)   tim_prdata = {29'b0, ch_en[c], mode[c], int_en[c]};
                if (off_sts)    tim_prdata = {30'b0, missed_rd[c], status[c]};
            end
        end
    end

    // Hardware events first, software writes last so they take priority
    always_comb begin
        int_en_nxt = int_en;
        mode_nxt   = mode;
        ch_en_nxt  = ch_en;
        status_nxt = (status & ~clr_status) | match;
        for (int c = 0; c < NUM_CH; c++) begin
            cmp_nxt[c] = cmp[c];
            prd_nxt[c] = prd[c];
            if (match[c]) begin
                if (mode[c] && (prd[c] != '0)) cmp_nxt[c] = cmp[c] + prd[c];
                else                           ch_en_nxt[c] = 1'b0;
            end
            if (wr_sel[c]) begin
                if (off_cmp_lo)
                    cmp_nxt[c] = CNT_W'({cmp_x[c][63:32],
                                         merge_bytes(cmp_x[c][31:0], tim_pwdata, tim_pstrb)});
                if (off_cmp_hi)
                    cmp_nxt[c] = CNT_W'({merge_bytes(cmp_x[c][63:32], tim_pwdata, tim_pstrb),
                                         cmp_x[c][31:0]});
                if (off_prd_lo)
                    prd_nxt[c] = CNT_W'({prd_x[c][63:32],
                                         merge_bytes(prd_x[c][31:0], tim_pwdata, tim_pstrb)});
                if (off_prd_hi)
                    prd_nxt[c] = CNT_W'({merge_bytes(prd_x[c][63:32], tim_pwdata, tim_pstrb),
                                         prd_x[c][31:0]});
                if (off_ctrl && tim_pstrb[0]) begin
                    int_en_nxt[c] = tim_pwdata[0];
                    mode_nxt[c]   = tim_pwdata[1];
                    ch_en_nxt[c]  = tim_pwdata[2];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cmp[c] <= '1;
                prd[c] <= '0;
            end
            int_en <= '0;
            mode   <= '0;
            ch_en  <= '0;
            status <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cmp[c] <= cmp_nxt[c];
                prd[c] <= prd_nxt[c];
            end
            int_en <= int_en_nxt;
            mode   <= mode_nxt;
            ch_en  <= ch_en_nxt;
            status <= status_nxt;
        end
    end

endmodule
